// File: rtl/csr_access_ctrl.sv
// ---------------------------------------------------------------------------
// csr_access_ctrl
//
// Runs each CSR instruction as an atomic read-modify-write on the single-port
// CSR register file, and shares that port with the trap unit, which writes
// mepc, mcause and mstatus directly.
//
// A request is accepted in IDLE, the old value is read in RD and the new
// value (RW/RS/RC rule) is written in WR. The old value goes back for rd
// writeback as a one-cycle response pulse in the WR cycle. Trap writes are
// only taken in IDLE, so they never split the read and write of one instruction.
//
// Ports:
//   clk, rst_n       clock (rising edge), synchronous active-low reset
//   req_*            EX-stage CSR instruction request (valid/ready)
//   rsp_*            response pulse: old CSR value and the illegal-op flag
//   trap_*           trap unit write request; trap_ready marks the write cycle
//   csr_raddr/rdata  combinational read port of the CSR file
//   csr_we/waddr/wdata  write port of the CSR file
//   busy             an instruction is in flight (state is not IDLE)
// ---------------------------------------------------------------------------
module csr_access_ctrl #(
  parameter int XLEN   = 32,
  parameter int CSR_AW = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [CSR_AW-1:0] req_addr,
  input  logic [XLEN-1:0]   req_op1,
  input  logic              req_wr_sup,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_data,
  output logic              rsp_illegal,
  input  logic              trap_valid,
  output logic              trap_ready,
  input  logic [CSR_AW-1:0] trap_addr,
  input  logic [XLEN-1:0]   trap_wdata,
  output logic [CSR_AW-1:0] csr_raddr,
  input  logic [XLEN-1:0]   csr_rdata,
  output logic              csr_we,
  output logic [CSR_AW-1:0] csr_waddr,
  output logic [XLEN-1:0]   csr_wdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [2:0]        op_q;
  logic [CSR_AW-1:0] addr_q;
  logic [XLEN-1:0]   op1_q;
  logic              wr_sup_q;
  logic [XLEN-1:0]   old_q;
  logic              rsp_valid_q;
  logic              rsp_illegal_q;

  logic              accept;
  logic              op_onehot;
  logic [XLEN-1:0]   new_val;

  // Anything other than exactly one op bit is an illegal encoding (000 included).
  assign op_onehot = (op_q == 3'b001) || (op_q == 3'b010) || (op_q == 3'b100);

  // New CSR value from the old value and the latched operand; purely bitwise.
  always_comb begin
    new_val = '0;
    case (op_q)
      3'b001:  new_val = op1_q;
      3'b010:  new_val = op1_q | old_q;
      3'b100:  new_val = ~op1_q & old_q;
      default: new_val = '0;
    endcase
  end

  // Next-state and port control. Trap writes are taken only in IDLE so an
  // instruction's read and write stay back-to-back. Everything handshake
  // related is forced low while rst_n is low, so a reset in RD or WR drops
  // the pending write.
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    trap_ready = 1'b0;
    csr_we     = 1'b0;
    csr_waddr  = '0;
    csr_wdata  = '0;
    accept     = 1'b0;

    case (state)
      IDLE: begin
        if (trap_valid) begin
          trap_ready = 1'b1;
          csr_we     = 1'b1;
          csr_waddr  = trap_addr;
          csr_wdata  = trap_wdata;
        end else begin
          req_ready = 1'b1;
          if (req_valid) begin
            accept    = 1'b1;
            state_nxt = RD;
          end
        end
      end
      RD: begin
        state_nxt = WR;
      end
      WR: begin
        state_nxt = IDLE;
        // op_q[0] is CSRRW once the encoding is known to be one-hot; CSRRW
        // writes even when rs1 is x0.
        if (op_onehot && !(wr_sup_q && !op_q[0])) begin
          csr_we    = 1'b1;
          csr_waddr = addr_q;
          csr_wdata = new_val;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (!rst_n) begin
      state_nxt  = IDLE;
      req_ready  = 1'b0;
      trap_ready = 1'b0;
      csr_we     = 1'b0;
      csr_waddr  = '0;
      csr_wdata  = '0;
      accept     = 1'b0;
    end
  end

  // State register, request latch and old-value capture. The response flags
  // are registered at the end of RD so they are valid for exactly the WR cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      op_q          <= '0;
      addr_q        <= '0;
      op1_q         <= '0;
      wr_sup_q      <= 1'b0;
      old_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_illegal_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q     <= req_op;
        addr_q   <= req_addr;
        op1_q    <= req_op1;
        wr_sup_q <= req_wr_sup;
      end
      if (state == RD) begin
        old_q <= csr_rdata;
      end
      rsp_valid_q   <= (state == RD);
      rsp_illegal_q <= (state == RD) && !op_onehot;
    end
  end

  assign csr_raddr   = addr_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = old_q;
  assign rsp_illegal = rsp_illegal_q;
  assign busy        = rst_n && (state != IDLE);

endmodule

// File: tb/tb_csr_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_csr_access_ctrl
//
// Directed bench for csr_access_ctrl with a behavioural CSR file. Stimulus
// pushes the expected responses and writes (value and cycle) into queues; a
// monitor on the falling edge pops and compares whenever rsp_valid or csr_we
// is seen, so any unexpected pulse or write is reported as well.
// ---------------------------------------------------------------------------
module tb_csr_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [11:0] req_addr;
  logic [31:0] req_op1;
  logic        req_wr_sup;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_illegal;
  logic        trap_valid;
  logic        trap_ready;
  logic [11:0] trap_addr;
  logic [31:0] trap_wdata;
  logic [11:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        busy;

  typedef struct {
    logic [31:0] data;
    logic        ill;
    int          cyc;
  } rsp_exp_t;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_exp_t;

  rsp_exp_t rsp_q[$];
  wr_exp_t  wr_q[$];
  rsp_exp_t mon_r;
  wr_exp_t  mon_w;

  logic [31:0] mem [0:4095];
  int          cyc;
  int          checks;
  int          errors;
  int          acc;
  int          n0;

  csr_access_ctrl #(.XLEN(32), .CSR_AW(12)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_op1    (req_op1),
    .req_wr_sup (req_wr_sup),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_illegal(rsp_illegal),
    .trap_valid (trap_valid),
    .trap_ready (trap_ready),
    .trap_addr  (trap_addr),
    .trap_wdata (trap_wdata),
    .csr_raddr  (csr_raddr),
    .csr_rdata  (csr_rdata),
    .csr_we     (csr_we),
    .csr_waddr  (csr_waddr),
    .csr_wdata  (csr_wdata),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index: a cycle's number is the value seen at its falling edge.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural CSR file: combinational read, write on the rising edge.
  assign csr_rdata = mem[csr_raddr];
  always @(posedge clk) begin
    if (csr_we) mem[csr_waddr] <= csr_wdata;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every response pulse and every file write must match the
  // oldest queued expectation, including the cycle it lands in.
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (rsp_q.size() == 0) begin
        check_output("unexpected_rsp_valid", 32'(rsp_valid), 32'd0);
      end else begin
        mon_r = rsp_q.pop_front();
        check_output("rsp_data", rsp_data, mon_r.data);
        check_output("rsp_illegal", 32'(rsp_illegal), 32'(mon_r.ill));
        check_output("rsp_cycle", 32'(cyc), 32'(mon_r.cyc));
      end
    end
    if (csr_we) begin
      if (wr_q.size() == 0) begin
        check_output("unexpected_csr_we", 32'(csr_we), 32'd0);
      end else begin
        mon_w = wr_q.pop_front();
        check_output("csr_waddr", 32'(csr_waddr), 32'(mon_w.addr));
        check_output("csr_wdata", csr_wdata, mon_w.data);
        check_output("csr_write_cycle", 32'(cyc), 32'(mon_w.cyc));
      end
    end
  end

  // Holds a request until accepted (bounded), queues its expected write and
  // response, and returns one step after the accepting edge (the RD cycle).
  task automatic apply_stimulus(input logic [2:0] op, input logic [11:0] addr,
                                input logic [31:0] op1, input logic sup,
                                input bit exp_we, input logic [31:0] exp_wdata,
                                input bit exp_rsp, input logic [31:0] exp_rdata,
                                input logic exp_ill, output int acc_cyc);
    req_valid  = 1'b1;
    req_op     = op;
    req_addr   = addr;
    req_op1    = op1;
    req_wr_sup = sup;
    acc_cyc    = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin
        acc_cyc = cyc;
        break;
      end
    end
    if (acc_cyc < 0) begin
      check_output("req_accept_timeout", 32'(req_ready), 32'd1);
    end else begin
      if (exp_we)  wr_q.push_back('{addr: addr, data: exp_wdata, cyc: acc_cyc + 2});
      if (exp_rsp) rsp_q.push_back('{data: exp_rdata, ill: exp_ill, cyc: acc_cyc + 2});
      @(posedge clk);
    end
    #1;
    req_valid = 1'b0;
    req_op    = 3'b000;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    mem[12'h300] = 32'h0000_1888;
    mem[12'h304] = 32'h0000_0800;
    mem[12'h305] = 32'h1234_5678;
    mem[12'h306] = 32'h0000_0077;
    mem[12'h307] = 32'h0000_0707;
    mem[12'h341] = 32'h0000_0055;

    // Reset with traffic on every input.
    rst_n      = 1'b0;
    req_valid  = 1'b1;
    req_op     = 3'b001;
    req_addr   = 12'h300;
    req_op1    = 32'hFFFF_FFFF;
    req_wr_sup = 1'b0;
    trap_valid = 1'b1;
    trap_addr  = 12'h341;
    trap_wdata = 32'hDEAD_BEEF;
    repeat (3) begin
      @(negedge clk);
      check_output("reset_csr_we", 32'(csr_we), 32'd0);
      check_output("reset_req_ready", 32'(req_ready), 32'd0);
      check_output("reset_trap_ready", 32'(trap_ready), 32'd0);
      check_output("reset_busy", 32'(busy), 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    req_valid  = 1'b0;
    trap_valid = 1'b0;
    @(negedge clk);
    check_output("post_reset_req_ready", 32'(req_ready), 32'd1);
    check_output("post_reset_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;

    $display("[TB] CSRRW / CSRRS / CSRRC");
    apply_stimulus(3'b001, 12'h300, 32'h0000_0008, 1'b0, 1, 32'h0000_0008, 1, 32'h0000_1888, 1'b0, acc);
    wait_cycles(2);
    apply_stimulus(3'b010, 12'h304, 32'h0000_0080, 1'b0, 1, 32'h0000_0880, 1, 32'h0000_0800, 1'b0, acc);
    wait_cycles(2);
    apply_stimulus(3'b100, 12'h304, 32'h0000_0800, 1'b0, 1, 32'h0000_0080, 1, 32'h0000_0880, 1'b0, acc);
    wait_cycles(2);

    $display("[TB] write suppression");
    apply_stimulus(3'b010, 12'h305, 32'h0000_00FF, 1'b1, 0, 32'h0, 1, 32'h1234_5678, 1'b0, acc);
    wait_cycles(2);
    apply_stimulus(3'b100, 12'h305, 32'hFFFF_FFFF, 1'b1, 0, 32'h0, 1, 32'h1234_5678, 1'b0, acc);
    wait_cycles(2);
    apply_stimulus(3'b001, 12'h305, 32'h0000_CAFE, 1'b1, 1, 32'h0000_CAFE, 1, 32'h1234_5678, 1'b0, acc);
    wait_cycles(2);
    apply_stimulus(3'b010, 12'h305, 32'h0000_0001, 1'b0, 1, 32'h0000_CAFF, 1, 32'h0000_CAFE, 1'b0, acc);
    wait_cycles(2);

    $display("[TB] trap arriving in RD waits for IDLE");
    apply_stimulus(3'b001, 12'h341, 32'h0000_0100, 1'b0, 1, 32'h0000_0100, 1, 32'h0000_0055, 1'b0, acc);
    wr_q.push_back('{addr: 12'h342, data: 32'h0000_000B, cyc: acc + 3});
    trap_addr  = 12'h342;
    trap_wdata = 32'h0000_000B;
    trap_valid = 1'b1;
    @(negedge clk);
    check_output("trap_wait_rd", 32'(trap_ready), 32'd0);
    check_output("busy_rd", 32'(busy), 32'd1);
    @(negedge clk);
    check_output("trap_wait_wr", 32'(trap_ready), 32'd0);
    @(negedge clk);
    check_output("trap_served_idle", 32'(trap_ready), 32'd1);
    check_output("req_ready_during_trap", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    trap_valid = 1'b0;

    $display("[TB] simultaneous trap and request in IDLE");
    n0 = cyc;
    wr_q.push_back('{addr: 12'h343, data: 32'h8000_0003, cyc: n0});
    trap_addr  = 12'h343;
    trap_wdata = 32'h8000_0003;
    trap_valid = 1'b1;
    fork
      begin
        @(negedge clk);
        check_output("simul_trap_ready", 32'(trap_ready), 32'd1);
        check_output("simul_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        trap_valid = 1'b0;
      end
      begin
        apply_stimulus(3'b010, 12'h300, 32'h0000_0010, 1'b0, 1, 32'h0000_0018, 1, 32'h0000_0008, 1'b0, acc);
      end
    join
    check_output("simul_req_accept_cycle", 32'(acc), 32'(n0 + 1));
    wait_cycles(2);

    $display("[TB] illegal encodings");
    apply_stimulus(3'b011, 12'h306, 32'hFFFF_FFFF, 1'b0, 0, 32'h0, 1, 32'h0000_0077, 1'b1, acc);
    wait_cycles(2);
    apply_stimulus(3'b000, 12'h306, 32'h0000_0001, 1'b0, 0, 32'h0, 1, 32'h0000_0077, 1'b1, acc);
    wait_cycles(2);

    $display("[TB] reset during RD");
    apply_stimulus(3'b001, 12'h307, 32'h0000_0009, 1'b0, 0, 32'h0, 0, 32'h0, 1'b0, acc);
    rst_n = 1'b0;
    @(negedge clk);
    check_output("midreset_csr_we", 32'(csr_we), 32'd0);
    check_output("midreset_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_cycles(3);
    check_output("midreset_idle_busy", 32'(busy), 32'd0);
    apply_stimulus(3'b010, 12'h307, 32'h0000_0000, 1'b1, 0, 32'h0, 1, 32'h0000_0707, 1'b0, acc);
    wait_cycles(4);

    check_output("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
    check_output("wr_queue_drained", 32'(wr_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/csr_access_ctrl.md
Name: csr_access_ctrl

Overview:
- Sequences every CSR instruction as an atomic read-modify-write on the single-port CSR register file.
- Arbitrates that port between the EX-stage CSR instruction path and the trap unit, which writes mepc, mcause and mstatus.
- Computes the new CSR value with the RW/RS/RC rules and returns the old CSR value for rd writeback.
- Sits between EX-stage decode and the CSR file.

Parameters:
- XLEN, 32, data width of CSR values and operands.
- CSR_AW, 12, CSR address width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- req_valid  input  1  CSR instruction request.
- req_ready  output  1  request accepted when req_valid & req_ready.
- req_op  input  3  one-hot operation: bit0 = CSRRW, bit1 = CSRRS, bit2 = CSRRC.
- req_addr  input  CSR_AW  target CSR address.
- req_op1  input  XLEN  rs1 data or zero-extended zimm.
- req_wr_sup  input  1  write suppression: rs1/zimm field is x0/0 for CSRRS or CSRRC.
- rsp_valid  output  1  one-cycle pulse; rsp_data is valid.
- rsp_data  output  XLEN  old CSR value for rd.
- rsp_illegal  output  1  qualified by rsp_valid; req_op was not one-hot.
- trap_valid  input  1  trap unit write request.
- trap_ready  output  1  trap write performed this cycle.
- trap_addr  input  CSR_AW  trap write address.
- trap_wdata  input  XLEN  trap write data.
- csr_raddr  output  CSR_AW  CSR file read address; the file read is combinational.
- csr_rdata  input  XLEN  CSR file read data.
- csr_we  output  1  CSR file write enable.
- csr_waddr  output  CSR_AW  CSR file write address.
- csr_wdata  output  XLEN  CSR file write data.
- busy  output  1  FSM is not in IDLE.

Behaviour:
- FSM states: IDLE, RD, WR. Reset value is IDLE.
- Reset values:
  - State registers: state = IDLE; rsp_valid, rsp_illegal, old_q and all latched request fields = 0.
  - Outputs while rst_n is low: csr_we, trap_ready, req_ready, busy = 0 (held low during reset).
  - Reset mid-operation abandons the access with no write and no response.
- IDLE:
  - trap_valid=1 has priority. trap_ready=1, csr_we=1, csr_waddr=trap_addr, csr_wdata=trap_wdata, all combinational in the same cycle. req_ready=0.
  - Otherwise req_ready=1. On req_valid, latch op, addr, op1, wr_sup and go to RD.
- RD:
  - csr_raddr = latched addr.
  - Capture csr_rdata into old_q at the clock edge, then go to WR.
  - req_ready=0, trap_ready=0.
- WR:
  - New value: RW → op1; RS → op1 | old_q; RC → ~op1 & old_q.
  - csr_we=1 unless any of: op is RS or RC with wr_sup=1; op is not one-hot. CSRRW always writes, regardless of wr_sup.
  - csr_waddr = latched addr.
  - rsp_valid=1 and rsp_data=old_q, both registered-through from latched state this cycle; rsp_illegal=1 when op is not one-hot.
  - Return to IDLE.
- Timing:
  - Request latency is acceptance cycle + 2 cycles to response.
  - Back-to-back throughput is one request per 3 cycles.
  - The read and write of one instruction are atomic; a trap arriving in RD or WR waits, at most 2 cycles, and is served first in the next IDLE cycle.
- Simultaneous events:
  - trap_valid and req_valid together in IDLE: the trap is served, and the request stays pending with req_ready=0.
  - The trap unit holds trap_valid until trap_ready.
  - A request held across trap cycles must keep its fields stable.
- Pins when unused:
  - csr_raddr = latched addr in all states.
  - csr_wdata and csr_waddr are don't-care when csr_we=0; drive them to 0.
- Width rules: all operations are bitwise XLEN; no carries.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with traffic on all inputs → csr_we=0, req_ready=0, rsp_valid=0 throughout. First cycle after release: req_ready=1.
- CSRRW: file[0x300]=0x0000_1888; request op=001, op1=0x0000_0008 → write of 0x0000_0008 to 0x300 two cycles after accept; rsp_data=0x0000_1888.
- CSRRS/CSRRC: file[0x304]=0x0000_0800.
  - CSRRS op1=0x80 → writes 0x880.
  - Then CSRRC op1=0x800 → writes 0x080; rsp_data=0x880.
- Write suppression: CSRRS wr_sup=1 → csr_we never asserted, rsp_data=old value. CSRRW wr_sup=1 → write occurs.
- Arbitration: trap_valid rises in the RD cycle of a request → trap_ready=0 in RD and WR, trap write in the following IDLE cycle. Simultaneous trap and request in IDLE → trap first, request accepted the next cycle.
- Illegal op: req_op=011 → no csr_we, rsp_valid with rsp_illegal=1. Mid-op reset in RD → no write, no rsp_valid.
